// File: rtl/random_range.sv
// Galois LFSR random source with on-request reduction of a sample into an inclusive range [min,max].
// A result appears WIDTH+1 cycles after an accepted request; requests arriving while busy are dropped.
module random_range #(
  parameter int               WIDTH     = 16,
  parameter int               OUT_WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
  parameter logic [WIDTH-1:0] SEED      = 16'hACE1
) (
  input  logic                 clk_random_range,
  input  logic                 rst_random_range,
  input  logic                 i_free_run,
  input  logic                 i_seed_load,
  input  logic [WIDTH-1:0]     i_seed,
  input  logic                 i_req,
  input  logic [OUT_WIDTH-1:0] i_min,
  input  logic [OUT_WIDTH-1:0] i_max,
  output logic                 o_busy,
  output logic                 o_valid,
  output logic [OUT_WIDTH-1:0] o_value
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int             RW   = OUT_WIDTH + 2;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
  localparam logic [OUT_WIDTH:0] ONE = {{OUT_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     lfsr_q, lfsr_step;
  logic [WIDTH-1:0]     sample_q;
  logic [OUT_WIDTH-1:0] lo_q, lo_d;
  logic [OUT_WIDTH:0]   span_q, span_d;
  logic [OUT_WIDTH:0]   rem_q, rem_sub, rem_next;
  logic [RW-1:0]        rem_shift;
  logic [CW-1:0]        cnt_q;
  logic                 accept;

  assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
  assign accept    = (state_q == IDLE) && i_req;
  assign o_busy    = (state_q != IDLE);

  always_comb begin
    lo_d   = i_min;
    span_d = {1'b0, i_max} - {1'b0, i_min} + ONE;
    if (i_min > i_max) begin
      lo_d   = i_max;
      span_d = {1'b0, i_min} - {1'b0, i_max} + ONE;
    end
  end

  // Remainder stays below span, so only the shifted value needs the extra bit;
  // the subtraction is exact in the narrower width.
  assign rem_shift = {rem_q, sample_q[WIDTH-1]};
  assign rem_sub   = rem_shift[OUT_WIDTH:0] - span_q;
  assign rem_next  = (rem_shift >= {1'b0, span_q}) ? rem_sub : rem_shift[OUT_WIDTH:0];

  always_ff @(posedge clk_random_range) begin
    if (rst_random_range) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_req) state_d = REDUCE;
      REDUCE:  if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_random_range) begin
    if (rst_random_range) begin
      lfsr_q   <= SEED;
      sample_q <= '0;
      lo_q     <= '0;
      span_q   <= ONE;
      rem_q    <= '0;
      cnt_q    <= '0;
      o_valid  <= 1'b0;
      o_value  <= '0;
    end else begin
      o_valid <= 1'b0;
      if (i_seed_load)                lfsr_q <= (i_seed == '0) ? SEED : i_seed;
      else if (accept || i_free_run)  lfsr_q <= lfsr_step;

      case (state_q)
        IDLE: if (i_req) begin
          sample_q <= lfsr_q;
          lo_q     <= lo_d;
          span_q   <= span_d;
          rem_q    <= '0;
          cnt_q    <= '0;
        end
        REDUCE: begin
          sample_q <= {sample_q[WIDTH-2:0], 1'b0};
          rem_q    <= rem_next;
          cnt_q    <= cnt_q + 1'b1;
        end
        DONE: begin
          o_value <= lo_q + rem_q[OUT_WIDTH-1:0];
          o_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_random_range.sv
// Scoreboard bench for random_range: expected results queued at request time, compared on o_valid.
module tb_random_range;

  logic        clk = 1'b0;
  logic        rst;
  logic        free_run;
  logic        seed_load;
  logic [15:0] seed;
  logic        req;
  logic [6:0]  vmin, vmax;
  logic        busy, valid;
  logic [6:0]  value;

  int          n_vec = 0;
  int          n_err = 0;
  logic [6:0]  exp_q[$];

  localparam logic [15:0] FREE_SEQ [3] = '{16'hE270, 16'h7138, 16'h389C};

  random_range dut (
    .clk_random_range (clk),
    .rst_random_range (rst),
    .i_free_run       (free_run),
    .i_seed_load      (seed_load),
    .i_seed           (seed),
    .i_req            (req),
    .i_min            (vmin),
    .i_max            (vmax),
    .o_busy           (busy),
    .o_valid          (valid),
    .o_value          (value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] step_model(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [6:0] range_model(input logic [15:0] s, input logic [6:0] a, input logic [6:0] b);
    int unsigned lo, hi;
    lo = (a < b) ? 32'(a) : 32'(b);
    hi = (a < b) ? 32'(b) : 32'(a);
    return 7'(lo + (32'(s) % (hi - lo + 1)));
  endfunction

  // Scoreboard side: every o_valid pulse consumes one queued expectation.
  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
      else                   check("value", 32'(value), 32'(exp_q.pop_front()));
    end
  end

  task automatic load_seed(input logic [15:0] s);
    seed_load = 1'b1; seed = s;
    @(posedge clk); #1;
    seed_load = 1'b0;
  endtask

  task automatic issue(input logic [6:0] mn, input logic [6:0] mx, input logic [6:0] expv);
    exp_q.push_back(expv);
    req = 1'b1; vmin = mn; vmax = mx;
    @(posedge clk); #1;
    req = 1'b0;
    check("busy_on", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int already);
    int cyc;
    cyc = already;
    while (!valid && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'd17);
    check("busy_off", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("valid_pulse", 32'(valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t[3];
    int n;
    logic [15:0] s;

    rst = 1'b1; free_run = 1'b1; seed_load = 1'b0; seed = '0;
    req = 1'b0; vmin = '0; vmax = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_value", 32'(value), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_lfsr",  32'(dut.lfsr_q), 32'h0000ACE1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("free_run_lfsr", 32'(dut.lfsr_q), 32'(FREE_SEQ[i]));
    end
    free_run = 1'b0;

    load_seed(16'h0064);
    check("seed_lfsr", 32'(dut.lfsr_q), 32'h64);
    issue(7'd0, 7'd6, 7'd2);
    wait_done(0);
    check("lfsr_once", 32'(dut.lfsr_q), 32'h32);

    load_seed(16'h0064); issue(7'd19, 7'd10, 7'd10); wait_done(0);
    load_seed(16'h0064); issue(7'd10, 7'd19, 7'd10); wait_done(0);
    load_seed(16'h0064); issue(7'd0, 7'd127, 7'd100); wait_done(0);
    issue(7'd33, 7'd33, 7'd33); wait_done(0);

    // Accept with free_run high must still step only once on the accept edge.
    free_run = 1'b1;
    load_seed(16'h0064);
    issue(7'd0, 7'd6, 7'd2);
    check("no_double_step", 32'(dut.lfsr_q), 32'h32);
    free_run = 1'b0;
    wait_done(0);

    // Seed load mid-reduction: LFSR changes, in-flight sample does not.
    load_seed(16'h0064);
    issue(7'd3, 7'd9, range_model(16'h0064, 7'd3, 7'd9));
    repeat (3) begin @(posedge clk); #1; end
    load_seed(16'h1234);
    check("seed_mid_reduce", 32'(dut.lfsr_q), 32'h1234);
    wait_done(4);

    // Held request: one result per 18 cycles, with a glitch on i_min mid-operation.
    load_seed(16'h0064);
    s = 16'h0064;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(range_model(s, 7'd5, 7'd40));
      s = step_model(s);
    end
    req = 1'b1; vmin = 7'd5; vmax = 7'd40;
    n = 0;
    for (int cyc = 1; cyc < 100; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 3) vmin = 7'd100;
      if (cyc == 4) vmin = 7'd5;
      if (valid) begin
        t[n] = cyc;
        n++;
        if (n == 3) begin
          req = 1'b0;
          break;
        end
      end
    end
    check("held_count", 32'(n), 32'd3);
    if (n == 3) begin
      check("held_period1", 32'(t[1] - t[0]), 32'd18);
      check("held_period2", 32'(t[2] - t[1]), 32'd18);
    end
    repeat (3) begin @(posedge clk); #1; end
    check("held_release_idle", 32'(busy), 32'd0);

    // Reset in the middle of a reduction aborts it cleanly.
    load_seed(16'h0064);
    issue(7'd0, 7'd6, 7'd2);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_lfsr",  32'(dut.lfsr_q), 32'h0000ACE1);
    repeat (25) begin @(posedge clk); #1; end

    load_seed(16'h0064);
    load_seed(16'h0000);
    check("seed_zero", 32'(dut.lfsr_q), 32'h0000ACE1);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
